// File: rtl/vga_timing_if.sv
// VGA raster timing bundle: pixel/line counters, sync strobes,
// blanking flags and end-of-frame strobe. master drives, slave consumes.
interface vga_timing_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        frame_end;

  modport master (
    output hcount, vcount, hsync, vsync,
    output hblnk, vblnk, frame_end
  );

  modport slave (
    input hcount, vcount, hsync, vsync,
    input hblnk, vblnk, frame_end
  );
endinterface

// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator (default 800x600@60, 40 MHz).
// Ports: pclk, rst_n (async, active-low), vga (master: counters/syncs/blanks/frame_end).
module vga_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic          pclk,
  input  logic          rst_n,
  vga_timing_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_BLANK  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_BLANK  = 12'(V_ACTIVE);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [11:0] hcount_q, hcount_d;
  logic [11:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        fend_q, fend_d;
  logic        h_wrap;
  logic        v_wrap;
  logic        hs_in;
  logic        vs_in;

  // Flags decode the next-state counters so that every flag
  // lines up with the count it belongs to on the same cycle.
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = h_wrap ? 12'd0 : hcount_q + 12'd1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? 12'd0 : vcount_q + 12'd1;
    end
    hs_in    = (hcount_d >= HS_START) && (hcount_d <= HS_END);
    vs_in    = (vcount_d >= VS_START) && (vcount_d <= VS_END);
    hblnk_d  = (hcount_d >= H_BLANK);
    vblnk_d  = (vcount_d >= V_BLANK);
    // XNOR with polarity: active level is SYNC_POL.
    hsync_d  = hs_in ~^ SYNC_POL;
    vsync_d  = vs_in ~^ SYNC_POL;
    fend_d   = (hcount_d == H_LAST) && (vcount_d == V_LAST);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      fend_q   <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      fend_q   <= fend_d;
    end
  end

  assign vga.hcount    = hcount_q;
  assign vga.vcount    = vcount_q;
  assign vga.hsync     = hsync_q;
  assign vga.vsync     = vsync_q;
  assign vga.hblnk     = hblnk_q;
  assign vga.vblnk     = vblnk_q;
  assign vga.frame_end = fend_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default raster, a small raster
// for full-frame checks, and an active-low reduced raster.
module tb_vga_timing;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 pclk = ~pclk;

  vga_timing_if d_if ();
  vga_timing_if s_if ();
  vga_timing_if p_if ();

  vga_timing u_d (
    .pclk  (pclk),
    .rst_n (rst_n),
    .vga   (d_if)
  );

  // H 16/4/8/4 -> 32, hsync 20..27; V 10/2/3/5 -> 20, vsync 12..14
  vga_timing #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(5),
    .SYNC_POL(1'b1)
  ) u_s (
    .pclk  (pclk),
    .rst_n (rst_n),
    .vga   (s_if)
  );

  // H 8/2/2/2 -> 14, hsync low 10..11; V 4/1/1/1 -> 7, vsync low at 5
  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0)
  ) u_p (
    .pclk  (pclk),
    .rst_n (rst_n),
    .vga   (p_if)
  );

  task automatic do_reset();
    @(negedge pclk);
    rst_n = 1'b0;
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge pclk);
    rst_n = 1'b0;
    repeat (5) @(negedge pclk);
    checks++;
    if (int'(d_if.hcount) !== 0 || int'(d_if.vcount) !== 0) begin
      errors++;
      $display("FAIL rst_count: got h=%0d v=%0d want h=0 v=0",
               d_if.hcount, d_if.vcount);
    end
    checks++;
    if ({d_if.hblnk, d_if.vblnk, d_if.frame_end} !== 3'b000) begin
      errors++;
      $display("FAIL rst_flags: got hb/vb/fe=%b want 000",
               {d_if.hblnk, d_if.vblnk, d_if.frame_end});
    end
    checks++;
    if ({d_if.hsync, d_if.vsync} !== 2'b00) begin
      errors++;
      $display("FAIL rst_sync_hi: got %b want 00", {d_if.hsync, d_if.vsync});
    end
    checks++;
    if ({p_if.hsync, p_if.vsync} !== 2'b11) begin
      errors++;
      $display("FAIL rst_sync_lo: got %b want 11", {p_if.hsync, p_if.vsync});
    end
    rst_n = 1'b1;
    @(negedge pclk);
    checks++;
    if (int'(d_if.hcount) !== 1 || int'(d_if.vcount) !== 0) begin
      errors++;
      $display("FAIL rst_first_edge: got h=%0d v=%0d want h=1 v=0",
               d_if.hcount, d_if.vcount);
    end
  endtask

  task automatic test_horizontal();
    int seq_bad = 0;
    int hs_cnt = 0;
    int hs_first = -1;
    int hs_last = -1;
    int hb_rise = -1;
    logic hb_1055 = 1'b0;
    logic hb_0 = 1'b1;
    int v_wrap = -1;
    do_reset();
    for (int k = 1; k <= 1057; k++) begin
      @(negedge pclk);
      if (int'(d_if.hcount) !== k % 1056 || int'(d_if.vcount) !== k / 1056)
        seq_bad++;
      if (d_if.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = k;
        hs_last = k;
      end
      if (d_if.hblnk && hb_rise < 0) hb_rise = k;
      if (k == 1055) hb_1055 = d_if.hblnk;
      if (k == 1056) begin
        hb_0 = d_if.hblnk;
        v_wrap = int'(d_if.vcount);
      end
    end
    checks++;
    if (seq_bad !== 0) begin
      errors++;
      $display("FAIL h_seq: got %0d bad cycles want 0", seq_bad);
    end
    checks++;
    if (hb_rise !== 800) begin
      errors++;
      $display("FAIL hblnk_rise: got hcount=%0d want 800", hb_rise);
    end
    checks++;
    if (hs_first !== 840 || hs_last !== 967) begin
      errors++;
      $display("FAIL hsync_span: got %0d..%0d want 840..967",
               hs_first, hs_last);
    end
    checks++;
    if (hs_cnt !== 128) begin
      errors++;
      $display("FAIL hsync_width: got %0d want 128", hs_cnt);
    end
    checks++;
    if (hb_1055 !== 1'b1 || hb_0 !== 1'b0) begin
      errors++;
      $display("FAIL hblnk_fall: got at1055=%b at0=%b want 1 0",
               hb_1055, hb_0);
    end
    checks++;
    if (v_wrap !== 1) begin
      errors++;
      $display("FAIL h_wrap_v: got vcount=%0d want 1", v_wrap);
    end
  endtask

  task automatic test_vertical();
    int seq_bad = 0;
    int vb_rise = -1;
    int vs_cnt = 0;
    int vs_first = -1;
    int vs_last = -1;
    int off_edge = 0;
    logic pv_b = 1'b0;
    logic pv_s = 1'b0;
    logic vb_639 = 1'b0;
    logic vb_640 = 1'b1;
    do_reset();
    for (int k = 1; k <= 641; k++) begin
      @(negedge pclk);
      if (int'(s_if.hcount) !== k % 32 ||
          int'(s_if.vcount) !== (k / 32) % 20)
        seq_bad++;
      if (s_if.vblnk && vb_rise < 0) vb_rise = k;
      if (s_if.vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = k;
        vs_last = k;
      end
      if ((s_if.vblnk !== pv_b || s_if.vsync !== pv_s) &&
          s_if.hcount !== 12'd0)
        off_edge++;
      pv_b = s_if.vblnk;
      pv_s = s_if.vsync;
      if (k == 639) vb_639 = s_if.vblnk;
      if (k == 640) vb_640 = s_if.vblnk;
    end
    checks++;
    if (seq_bad !== 0) begin
      errors++;
      $display("FAIL v_seq: got %0d bad cycles want 0", seq_bad);
    end
    checks++;
    if (vb_rise !== 320) begin
      errors++;
      $display("FAIL vblnk_rise: got cycle %0d want 320", vb_rise);
    end
    checks++;
    if (vs_first !== 384 || vs_last !== 479 || vs_cnt !== 96) begin
      errors++;
      $display("FAIL vsync_span: got %0d..%0d n=%0d want 384..479 n=96",
               vs_first, vs_last, vs_cnt);
    end
    checks++;
    if (off_edge !== 0) begin
      errors++;
      $display("FAIL vflag_align: got %0d changes off hcount0 want 0",
               off_edge);
    end
    checks++;
    if (vb_639 !== 1'b1 || vb_640 !== 1'b0) begin
      errors++;
      $display("FAIL vblnk_fall: got %b%b want 10", vb_639, vb_640);
    end
  endtask

  task automatic test_frame_end();
    int fe_cnt = 0;
    int fe1 = -1;
    int fe2 = -1;
    int fe_bad = 0;
    do_reset();
    for (int k = 1; k <= 1300; k++) begin
      @(negedge pclk);
      if (s_if.frame_end) begin
        fe_cnt++;
        if (fe1 < 0) fe1 = k;
        else if (fe2 < 0) fe2 = k;
        if (s_if.hcount !== 12'd31 || s_if.vcount !== 12'd19) fe_bad++;
      end
    end
    checks++;
    if (fe_cnt !== 2) begin
      errors++;
      $display("FAIL fe_count: got %0d want 2", fe_cnt);
    end
    checks++;
    if (fe1 !== 639) begin
      errors++;
      $display("FAIL fe_first: got cycle %0d want 639", fe1);
    end
    checks++;
    if (fe2 - fe1 !== 640) begin
      errors++;
      $display("FAIL fe_period: got %0d want 640", fe2 - fe1);
    end
    checks++;
    if (fe_bad !== 0) begin
      errors++;
      $display("FAIL fe_pos: got %0d off-corner pulses want 0", fe_bad);
    end
  endtask

  task automatic test_async_reset();
    int seq_bad = 0;
    int hs_first = -1;
    int hb_rise = -1;
    do_reset();
    repeat (1956) @(negedge pclk);
    checks++;
    if (int'(d_if.hcount) !== 900 || int'(d_if.vcount) !== 1 ||
        d_if.hsync !== 1'b1 || d_if.hblnk !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre: got h=%0d v=%0d hs=%b hb=%b want 900 1 1 1",
               d_if.hcount, d_if.vcount, d_if.hsync, d_if.hblnk);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (int'(d_if.hcount) !== 0 || int'(d_if.vcount) !== 0 ||
        d_if.hsync !== 1'b0 || d_if.hblnk !== 1'b0 ||
        d_if.frame_end !== 1'b0) begin
      errors++;
      $display("FAIL ar_immediate: got h=%0d v=%0d hs=%b hb=%b want 0 0 0 0",
               d_if.hcount, d_if.vcount, d_if.hsync, d_if.hblnk);
    end
    @(negedge pclk);
    rst_n = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge pclk);
      if (int'(d_if.hcount) !== k || int'(d_if.vcount) !== 0) seq_bad++;
      if (d_if.hsync && hs_first < 0) hs_first = k;
      if (d_if.hblnk && hb_rise < 0) hb_rise = k;
    end
    checks++;
    if (seq_bad !== 0 || hs_first !== 840 || hb_rise !== 800) begin
      errors++;
      $display("FAIL ar_restart: got bad=%0d hs=%0d hb=%0d want 0 840 800",
               seq_bad, hs_first, hb_rise);
    end
  endtask

  task automatic test_polarity();
    int seq_bad = 0;
    int hs_low = 0;
    int vs_low = 0;
    int place_bad = 0;
    int fe_at = -1;
    int h97 = -1;
    int v97 = -1;
    int h98 = -1;
    int v98 = -1;
    do_reset();
    for (int k = 1; k <= 99; k++) begin
      @(negedge pclk);
      if (int'(p_if.hcount) !== k % 14 ||
          int'(p_if.vcount) !== (k / 14) % 7)
        seq_bad++;
      if (!p_if.hsync) begin
        hs_low++;
        if (k % 14 < 10 || k % 14 > 11) place_bad++;
      end
      if (!p_if.vsync) begin
        vs_low++;
        if ((k / 14) % 7 != 5) place_bad++;
      end
      if (p_if.frame_end) fe_at = k;
      if (k == 97) begin
        h97 = int'(p_if.hcount);
        v97 = int'(p_if.vcount);
      end
      if (k == 98) begin
        h98 = int'(p_if.hcount);
        v98 = int'(p_if.vcount);
      end
    end
    checks++;
    if (seq_bad !== 0) begin
      errors++;
      $display("FAIL p_seq: got %0d bad cycles want 0", seq_bad);
    end
    checks++;
    if (hs_low !== 14 || vs_low !== 14 || place_bad !== 0) begin
      errors++;
      $display("FAIL p_sync_low: got hs=%0d vs=%0d bad=%0d want 14 14 0",
               hs_low, vs_low, place_bad);
    end
    checks++;
    if (h97 !== 13 || v97 !== 6 || h98 !== 0 || v98 !== 0) begin
      errors++;
      $display("FAIL p_wrap: got (%0d,%0d)->(%0d,%0d) want (13,6)->(0,0)",
               h97, v97, h98, v98);
    end
    checks++;
    if (fe_at !== 97) begin
      errors++;
      $display("FAIL p_frame_end: got cycle %0d want 97", fe_at);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_frame_end();
    test_async_reset();
    test_polarity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Free-running VGA raster timing generator. It sits directly upstream of the background/pixel drawing stage.
- It produces the 12-bit horizontal and vertical pixel counters, sync strobes and blanking flags that the draw pipeline consumes.
- Defaults give 800x600 @ 60 Hz, driven by a 40 MHz pixel clock.
- It also emits a one-cycle end-of-frame strobe, used by game logic to update snake state between frames.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, 1 = active-high sync pulses, 0 = active-low

Ports:
- pclk  in  1  pixel clock; all logic is on its rising edge
- rst_n  in  1  asynchronous active-low reset
- vcount  out  12  current line, 0..V_TOTAL-1
- vsync  out  1  vertical sync, polarity per SYNC_POL
- vblnk  out  1  vertical blanking, active high
- hcount  out  12  current pixel in line, 0..H_TOTAL-1
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- hblnk  out  1  horizontal blanking, active high
- frame_end  out  1  one-cycle strobe on the last pixel of each frame

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628)
  - Both totals must be <= 4096. Out-of-range parameter values are unsupported; no runtime check.
- Reset:
  - One clock domain. Reset is asynchronous, active-low, and asserts immediately regardless of pclk.
  - While rst_n=0: hcount=0, vcount=0, hblnk=0, vblnk=0, frame_end=0, hsync=vsync=!SYNC_POL (inactive level).
  - First rising edge after rst_n deasserts advances hcount to 1.
  - Reset asserted mid-frame returns all outputs to the reset values at once. Counting restarts from (0,0); no partial-frame recovery.
- Counters (all outputs registered, no combinational paths to ports):
  - hcount increments by 1 every pclk.
  - At hcount == H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0 on the same edge.
  - vcount changes only on the edge where hcount wraps.
- Flags (registered from the next-state counters so they align with the count on the same cycle):
  - hblnk = 1 iff H_ACTIVE <= hcount <= H_TOTAL-1.
  - hsync active iff H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1. Default: 840..967.
  - vblnk = 1 iff vcount >= V_ACTIVE.
  - vsync active iff V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1. Default: 601..604.
  - vsync and vblnk change only together with vcount, i.e. at hcount 0.
- frame_end:
  - 1 exactly in the cycle where hcount==H_TOTAL-1 and vcount==V_TOTAL-1, otherwise 0.
  - Period is H_TOTAL*V_TOTAL cycles (default 663168).
- Latency: none beyond the register stage. Outputs are mutually consistent on every cycle.
- Downstream contract: the draw stage adds its own 2-cycle delay to all of these signals. This block does not delay them.

Test Plan:
- Reset:
  - Hold rst_n=0 for 5 cycles -> hcount=0, vcount=0, hblnk=vblnk=0, hsync=vsync=0 (SYNC_POL=1), frame_end=0.
  - Release rst_n -> hcount reads 1 after the first edge.
- Horizontal timing: run one line from reset ->
  - hblnk rises with hcount=800.
  - hsync high exactly for hcount 840..967 (128 cycles).
  - hcount wraps 1055->0 while vcount steps 0->1.
  - hblnk falls with hcount=0.
- Vertical timing: run to vcount=600 ->
  - vblnk rises at (hcount=0, vcount=600).
  - vsync high for vcount 601..604, i.e. 4*1056 = 4224 cycles.
  - At frame wrap, (1055,627) -> (0,0) and vblnk falls.
- Frame strobe: run 2 full frames ->
  - frame_end pulses exactly twice, each for 1 cycle, at (1055,627).
  - Pulses are 663168 cycles apart.
- Async reset mid-frame: drop rst_n between edges at (hcount=500, vcount=300) ->
  - Outputs reach reset values before the next pclk edge.
  - After release, counting restarts from 0 with correct flags.
- Parameter/polarity: SYNC_POL=0 with a reduced raster (H 8/2/2/2, V 4/1/1/1) ->
  - hsync low only at hcount 10..11, vsync low only at vcount 5.
  - H_TOTAL=14 and V_TOTAL=7 are confirmed by wrap points.
